// File: rtl/rom_loader_bridge.sv
// Bridges the HPS ioctl byte-download port to a core loader through a small FIFO,
// issuing one held write per byte and completing each on a rising acknowledge edge.
module rom_loader_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 19
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] ldr_adr,
    output logic [7:0]    ldr_wdat,
    output logic          ldr_oe,
    output logic          ldr_wr,
    input  logic          ldr_ack,
    output logic          ldr_done,
    output logic [1:0]    ldr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_dl_prev;
    logic          r_ack_prev;
    logic          r_armed;
    logic          r_wait;
    logic          r_oe;
    logic          r_wr;
    logic          r_done;
    logic [AW-1:0] r_adr;
    logic [7:0]    r_wdat;
    logic [1:0]    r_err;

    logic w_dl_rise;
    logic w_dl_fall;
    logic w_ack_rise;
    logic w_in_range;
    logic w_full;
    logic w_empty;
    logic w_active;
    logic w_wr_load;
    logic w_push;
    logic w_pop;
    logic w_drop_range;
    logic w_drop_full;
    logic w_start;

    // A download already high out of reset must fall before it can open a window
    assign w_dl_rise    = ioctl_download & ~r_dl_prev & r_armed;
    assign w_dl_fall    = ~ioctl_download & r_dl_prev;
    assign w_ack_rise   = ldr_ack & ~r_ack_prev;
    assign w_in_range   = ((ioctl_addr >> AW) == 25'd0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == {CW{1'b0}});
    assign w_active     = (r_state == LOAD) || (r_state == DRAIN);
    assign w_wr_load    = (r_state == LOAD) && ioctl_wr;
    assign w_push       = w_wr_load && w_in_range && !w_full;
    assign w_drop_range = w_wr_load && !w_in_range;
    assign w_drop_full  = w_wr_load && w_in_range && w_full;
    assign w_pop        = w_active && !r_wr && !w_empty;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dl_rise) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (w_dl_fall) w_state_nxt = DRAIN;
                else           w_state_nxt = LOAD;
            end
            DRAIN: begin
                if (w_empty && !r_wr) w_state_nxt = DONE;
                else                  w_state_nxt = DRAIN;
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Occupancy after this edge
    always_comb begin
        w_count_nxt = r_count;
        if (w_start)                 w_count_nxt = {CW{1'b0}};
        else if (w_push && !w_pop)   w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_push)   w_count_nxt = r_count - CW'(1);
        else                         w_count_nxt = r_count;
    end

    // State register and input edge history
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dl_prev  <= 1'b0;
            r_ack_prev <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dl_prev  <= ioctl_download;
            r_ack_prev <= ldr_ack;
            if (!ioctl_download) r_armed <= 1'b1;
        end
    end

    // FIFO storage; contents are only consumed when the occupancy marks them valid
    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wptr] <= {ioctl_addr[AW-1:0], ioctl_dout};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_start) begin
                r_wptr <= {PW{1'b0}};
                r_rptr <= {PW{1'b0}};
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Loader beat, status flags and back-pressure
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_adr  <= {AW{1'b0}};
            r_wdat <= 8'h00;
            r_done <= 1'b0;
            r_err  <= 2'b00;
            r_wait <= 1'b0;
            r_oe   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wr            <= 1'b1;
                {r_adr, r_wdat} <= r_mem[r_rptr];
            end else if (r_wr && w_ack_rise) begin
                r_wr <= 1'b0;
            end
            if (w_start) r_err <= 2'b00;
            else         r_err <= r_err | {w_drop_full, w_drop_range};
            if ((r_state == DRAIN) && (w_state_nxt == DONE)) r_done <= 1'b1;
            r_wait <= (w_state_nxt == LOAD) && (w_count_nxt >= CW'(DEPTH - 1));
            r_oe   <= (w_state_nxt == LOAD) || (w_state_nxt == DRAIN);
        end
    end

    assign ioctl_wait = r_wait;
    assign ldr_adr    = r_adr;
    assign ldr_wdat   = r_wdat;
    assign ldr_oe     = r_oe;
    assign ldr_wr     = r_wr;
    assign ldr_done   = r_done;
    assign ldr_err    = r_err;

endmodule
